// File: rtl/s2p_if.sv
// Serial-in / parallel-out handshake bundle for s2p.
// The slave modport is the converter's own view; master is the link/sink side.
interface s2p_if #(
  parameter int N = 8
);
  logic         ser_valid;
  logic         ser_data;
  logic         ser_ready;
  logic         flush;
  logic         par_valid;
  logic [N-1:0] par_data;
  logic         par_ready;

  modport slave (
    input  ser_valid, ser_data, flush, par_ready,
    output ser_ready, par_valid, par_data
  );

  modport master (
    output ser_valid, ser_data, flush, par_ready,
    input  ser_ready, par_valid, par_data
  );
endinterface

// File: rtl/s2p.sv
// Serial-to-parallel converter: collects N bits LSB first and presents them as one word.
// Double-buffered: a finished word may wait in the shift register while the output register is stalled.
module s2p #(
  parameter int N = 8
) (
  input  logic   clk,
  input  logic   rstn,
  s2p_if.slave   bus,
  output logic   dbg_state
);
  localparam int CW = $clog2(N);

  // Valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
  // valid and its data hold steady until that edge, and ready never depends combinationally on valid.
  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [N-1:0]  shift, shift_n;
  logic [N-1:0]  par_data, par_data_n;
  logic          par_valid, par_valid_n;

  logic          bit_acc;
  logic          slot_free;
  logic [N-1:0]  word;

  assign bus.ser_ready = (state == COLLECT);
  assign bus.par_valid = par_valid;
  assign bus.par_data  = par_data;
  assign dbg_state     = state;

  assign bit_acc   = bus.ser_valid & (state == COLLECT);
  assign slot_free = !par_valid | bus.par_ready;
  assign word      = {bus.ser_data, shift[N-1:1]};

  always_comb begin
    state_n     = state;
    count_n     = count;
    shift_n     = shift;
    par_data_n  = par_data;
    par_valid_n = par_valid & !bus.par_ready;
    if (bus.flush) begin
      // Output register is left alone so a presented word is never retracted.
      state_n = COLLECT;
      count_n = '0;
      shift_n = '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bit_acc) begin
            shift_n = word;
            if (count == CW'(N-1)) begin
              count_n = '0;
              if (slot_free) begin
                par_data_n  = word;
                par_valid_n = 1'b1;
              end else begin
                state_n = FULL;
              end
            end else begin
              count_n = count + CW'(1);
            end
          end
        end
        FULL: begin
          if (slot_free) begin
            par_data_n  = shift;
            par_valid_n = 1'b1;
            state_n     = COLLECT;
          end
        end
        default: state_n = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= COLLECT;
      count     <= '0;
      shift     <= '0;
      par_data  <= '0;
      par_valid <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      shift     <= shift_n;
      par_data  <= par_data_n;
      par_valid <= par_valid_n;
    end
  end
endmodule

// File: tb/tb_s2p.sv
// Bench for s2p: directed scenarios then random traffic, all checked against a word-level model.
module tb_s2p;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rstn;
  logic dbg_state;

  s2p_if #(.N(N)) bus ();

  s2p #(.N(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bits gathered by position, one optional waiting word, one presented word.
  int           m_n;
  logic [N-1:0] m_acc;
  logic         m_held;
  logic [N-1:0] m_hw;
  logic         m_pv;
  logic [N-1:0] m_pd;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_acc = '0; m_held = 1'b0; m_hw = '0; m_pv = 1'b0; m_pd = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic         slot;
    logic         nv;
    logic [N-1:0] w;
    slot = !m_pv || bus.par_ready;
    nv   = m_pv && !bus.par_ready;
    if (m_pv && bus.par_ready) begin
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("sink_word", bus.par_data, w);
      end
    end
    if (bus.flush) begin
      m_n = 0; m_acc = '0;
      if (m_held) begin
        void'(exp_q.pop_back());
        m_held = 1'b0;
      end
    end else if (m_held) begin
      if (slot) begin
        m_pd = m_hw; nv = 1'b1; m_held = 1'b0;
      end
    end else if (bus.ser_valid) begin
      m_acc[m_n] = bus.ser_data;
      m_n++;
      if (m_n == N) begin
        exp_q.push_back(m_acc);
        if (slot) begin
          m_pd = m_acc; nv = 1'b1;
        end else begin
          m_held = 1'b1; m_hw = m_acc;
        end
        m_n = 0; m_acc = '0;
      end
    end
    m_pv = nv;
  endtask

  // One clock: compare outputs with the model, advance the model, move to just after the edge.
  task automatic tick();
    chk("ser_ready", bus.ser_ready, !m_held);
    chk("par_valid", bus.par_valid, m_pv);
    chk("par_data", bus.par_data, m_pd);
    chk("dbg_state", dbg_state, m_held);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int guard;
    bus.ser_valid = 1'b1;
    bus.ser_data  = b;
    guard = 0;
    while (m_held && guard < 40) begin
      tick();
      guard++;
    end
    chk("send_bound", guard < 40, 1);
    tick();
  endtask

  task automatic send_word(input logic [N-1:0] w);
    for (int i = 0; i < N; i++) send_bit(w[i]);
    bus.ser_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_par_valid", bus.par_valid, 0);
    chk("rst_par_data", bus.par_data, 0);
    chk("rst_ser_ready", bus.ser_ready, 1);
    chk("rst_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn          = 1'b1;
    bus.ser_valid = 1'b0;
    bus.ser_data  = 1'b0;
    bus.flush     = 1'b0;
    bus.par_ready = 1'b0;
    model_reset();
    #2;
    do_reset();

    // 1: single word 1,0,1,1,0,0,1,0 -> 8'h4D one cycle after the last bit
    bus.par_ready = 1'b1;
    send_word(8'h4D);
    chk("t1_valid", bus.par_valid, 1);
    chk("t1_data", bus.par_data, 8'h4D);
    tick();
    chk("t1_valid_drop", bus.par_valid, 0);

    // 2: back-to-back stream, ready never drops
    send_word(8'hA5);
    chk("t2_w0", bus.par_data, 8'hA5);
    send_word(8'h3C);
    chk("t2_w1", bus.par_data, 8'h3C);
    chk("t2_ready", bus.ser_ready, 1);
    send_word(8'hFF);
    chk("t2_w2", bus.par_data, 8'hFF);
    chk("t2_ready_end", bus.ser_ready, 1);
    tick();

    // 3: stalled sink fills both buffers
    bus.par_ready = 1'b0;
    send_word(8'hA5);
    send_word(8'h5A);
    chk("t3_ready_low", bus.ser_ready, 0);
    chk("t3_hold", bus.par_data, 8'hA5);
    tick();
    tick();
    chk("t3_hold_stable", bus.par_data, 8'hA5);
    bus.par_ready = 1'b1;
    tick();
    bus.par_ready = 1'b0;
    chk("t3_next", bus.par_data, 8'h5A);
    chk("t3_next_valid", bus.par_valid, 1);
    chk("t3_ready_back", bus.ser_ready, 1);
    bus.par_ready = 1'b1;
    tick();
    chk("t3_drained", bus.par_valid, 0);

    // 4: partial word flushed, concurrent bit dropped
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    bus.flush = 1'b1;
    bus.ser_data = 1'b1;
    tick();
    bus.flush = 1'b0;
    send_word(8'h81);
    chk("t4_data", bus.par_data, 8'h81);
    tick();

    // 5: flush while FULL discards only the waiting word
    bus.par_ready = 1'b0;
    send_word(8'h33);
    send_word(8'hCC);
    chk("t5_full", dbg_state, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t5_ready", bus.ser_ready, 1);
    chk("t5_kept", bus.par_data, 8'h33);
    chk("t5_kept_valid", bus.par_valid, 1);
    bus.par_ready = 1'b1;
    tick();
    chk("t5_no_ghost", bus.par_valid, 0);

    // 6: async reset mid-word and during FULL, then a gapped word
    bus.par_ready = 1'b0;
    send_word(8'h96);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    bus.ser_valid = 1'b0;
    do_reset();
    send_word(8'h12);
    send_word(8'h34);
    do_reset();
    bus.par_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      logic [N-1:0] w;
      w = 8'h6B;
      send_bit(w[i]);
      bus.ser_valid = 1'b0;
      if (i != N-1) repeat ($urandom_range(1, 2)) tick();
    end
    chk("t6_gap_word", bus.par_data, 8'h6B);
    chk("t6_gap_valid", bus.par_valid, 1);
    tick();

    // random traffic with occasional flush
    for (int c = 0; c < 600; c++) begin
      bus.ser_valid = ($urandom_range(0, 3) != 0);
      bus.ser_data  = 1'($urandom_range(0, 1));
      bus.par_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    bus.ser_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.par_ready = 1'b1;
    repeat (4) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
